pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_pkg.sv | 23 ++
 rtl/pc_ctrl_branch_decide.sv | 34 +++
 rtl/pc_ctrl.sv | 108 ++++++++++
 tb/tb_pc_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter controller.
//   state_t          : controller FSM states
//   F3_*             : funct3 encodings of the conditional branches
//   RESET_PC_DEFAULT : default PC loaded on reset
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ctrl_branch_decide.sv
// Branch condition evaluation (purely combinational).
//   funct3     : branch condition field
//   is_branch  : instruction is a conditional branch
//   br_less    : comparator less-than result
//   br_equal   : comparator equality result
//   cond_taken : branch condition holds (0 when not a branch or for 010/011)
module branch_decide
  import pc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_branch,
  input  logic       br_less,
  input  logic       br_equal,
  output logic       cond_taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = br_equal;
      F3_BNE:  cond = ~br_equal;
      F3_BLT:  cond = br_less;
      F3_BGE:  cond = ~br_less;
      F3_BLTU: cond = br_less;
      F3_BGEU: cond = ~br_less;
      default: cond = 1'b0;
    endcase
  end

  assign cond_taken = is_branch & cond;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: fetch/execute sequencing, branch/jump
// resolution, misaligned-target trap and retired-instruction counting.
//   clk, rst            : clock, synchronous active-high reset
//   br_less, br_equal   : branch comparator results
//   is_branch/jal/jalr  : instruction class of the instruction in execute
//   funct3              : branch condition field
//   target              : ALU-computed jump/branch target
//   stall               : hold instruction in execute
//   imem_ready          : instruction memory accepts the fetch
//   imem_req            : fetch request for address pc
//   pc, pc_four         : current PC and PC + 4
//   br_unsigned         : comparator unsigned mode (funct3[1])
//   taken               : control transfer taken this cycle
//   misaligned          : sticky misaligned-target trap flag
//   instret             : retired-instruction counter
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_less,
  input  logic        br_equal,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic        br_unsigned,
  output logic        taken,
  output logic        misaligned,
  output logic [31:0] instret
);

  state_t      state, state_n;
  logic [31:0] pc_n, instret_n;
  logic        misaligned_n;
  logic        cond_taken;
  logic        xfer;
  logic [31:0] eff_target;

  branch_decide u_branch_decide (
    .funct3     (funct3),
    .is_branch  (is_branch),
    .br_less    (br_less),
    .br_equal   (br_equal),
    .cond_taken (cond_taken)
  );

  assign pc_four     = pc + 32'd4;
  assign br_unsigned = funct3[1];
  assign xfer        = is_jal | is_jalr | cond_taken;
  assign eff_target  = is_jalr ? {target[31:1], 1'b0} : target;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    instret_n    = instret;
    misaligned_n = misaligned;
    imem_req     = 1'b0;
    taken        = 1'b0;
    case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_n = S_EXEC;
      end
      S_EXEC: begin
        taken = xfer;
        if (!stall) begin
          // Only a taken transfer can trap; a not-taken branch with a
          // misaligned target simply falls through to pc + 4.
          if (xfer && (eff_target[1:0] != 2'b00)) begin
            state_n      = S_TRAP;
            misaligned_n = 1'b1;
          end else begin
            pc_n      = xfer ? eff_target : pc_four;
            instret_n = instret + 32'd1;
            state_n   = S_FETCH;
          end
        end
      end
      S_TRAP: misaligned_n = 1'b1;
      default: state_n = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      instret    <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      instret    <= instret_n;
      misaligned <= misaligned_n;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_less, br_equal;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [31:0] target;
  logic        stall, imem_ready;
  logic        imem_req;
  logic [31:0] pc, pc_four, instret;
  logic        br_unsigned, taken, misaligned;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .br_less     (br_less),
    .br_equal    (br_equal),
    .is_branch   (is_branch),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .funct3      (funct3),
    .target      (target),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .imem_req    (imem_req),
    .pc          (pc),
    .pc_four     (pc_four),
    .br_unsigned (br_unsigned),
    .taken       (taken),
    .misaligned  (misaligned),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_instr();
    br_less = 0; br_equal = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 3'b000; target = '0; stall = 0;
  endtask

  initial begin
    rst = 1; imem_ready = 0;
    clr_instr();
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_taken", {31'b0, taken}, 32'h0);

    // First cycle after reset: still S_RESET, no fetch.
    rst = 0; imem_ready = 1; #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'h0);
    tick();  // S_FETCH
    chk("fetch_req", {31'b0, imem_req}, 32'h1);
    chk("fetch_pc", pc, 32'h0);
    tick();  // S_EXEC, non-branch
    chk("exec_req", {31'b0, imem_req}, 32'h0);
    chk("exec_taken", {31'b0, taken}, 32'h0);
    chk("pc_four0", pc_four, 32'h4);
    tick();
    chk("seq_pc", pc, 32'h4);
    chk("seq_instret", instret, 32'h1);

    // BEQ taken
    tick();
    is_branch = 1; funct3 = 3'b000; br_equal = 1; target = 32'h100; #1;
    chk("beq_taken", {31'b0, taken}, 32'h1);
    chk("beq_unsigned", {31'b0, br_unsigned}, 32'h0);
    tick(); clr_instr();
    chk("beq_pc", pc, 32'h100);
    chk("beq_instret", instret, 32'h2);

    // BEQ not taken
    tick();
    is_branch = 1; funct3 = 3'b000; br_equal = 0; target = 32'h200; #1;
    chk("beqn_taken", {31'b0, taken}, 32'h0);
    tick(); clr_instr();
    chk("beqn_pc", pc, 32'h104);
    chk("beqn_instret", instret, 32'h3);

    // BLTU taken
    tick();
    is_branch = 1; funct3 = 3'b110; br_less = 1; target = 32'h40; #1;
    chk("bltu_unsigned", {31'b0, br_unsigned}, 32'h1);
    chk("bltu_taken", {31'b0, taken}, 32'h1);
    tick(); clr_instr();
    chk("bltu_pc", pc, 32'h40);

    // funct3=010 never taken; misaligned target must not trap
    tick();
    is_branch = 1; funct3 = 3'b010; br_less = 1; br_equal = 1; target = 32'h203; #1;
    chk("f010_taken", {31'b0, taken}, 32'h0);
    tick(); clr_instr();
    chk("f010_pc", pc, 32'h44);
    chk("f010_mis", {31'b0, misaligned}, 32'h0);
    chk("f010_instret", instret, 32'h5);

    // BNE taken with br_equal=0
    tick();
    is_branch = 1; funct3 = 3'b001; target = 32'h48; #1;
    chk("bne_taken", {31'b0, taken}, 32'h1);
    tick(); clr_instr();
    chk("bne_pc", pc, 32'h48);

    // imem_ready low 3 cycles, then stall 2 cycles with a JAL pending
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", {31'b0, imem_req}, 32'h1);
      chk("wait_pc", pc, 32'h48);
      chk("wait_instret", instret, 32'h6);
    end
    imem_ready = 1;
    tick();  // S_EXEC
    stall = 1; is_jal = 1; target = 32'h80;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pc", pc, 32'h48);
      chk("stall_instret", instret, 32'h6);
      chk("stall_req", {31'b0, imem_req}, 32'h0);
    end
    stall = 0;
    tick(); clr_instr();
    chk("jal_pc", pc, 32'h80);
    chk("jal_instret", instret, 32'h7);

    // Jump to top of address space, then sequential wrap
    tick();
    is_jal = 1; target = 32'hFFFF_FFFC;
    tick(); clr_instr();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_four", pc_four, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instret", instret, 32'h9);

    // JALR clears target bit 0
    tick();
    is_jalr = 1; target = 32'h205;
    tick(); clr_instr();
    chk("jalr_pc", pc, 32'h204);
    chk("jalr_mis", {31'b0, misaligned}, 32'h0);

    // JALR misaligned -> trap
    tick();
    is_jalr = 1; target = 32'h203; #1;
    chk("trap_taken_pre", {31'b0, taken}, 32'h1);
    tick(); clr_instr();
    chk("trap_mis", {31'b0, misaligned}, 32'h1);
    chk("trap_pc", pc, 32'h204);
    chk("trap_instret", instret, 32'hA);
    is_jal = 1; target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("trap_hold_pc", pc, 32'h204);
      chk("trap_hold_req", {31'b0, imem_req}, 32'h0);
      chk("trap_hold_taken", {31'b0, taken}, 32'h0);
      chk("trap_hold_mis", {31'b0, misaligned}, 32'h1);
    end
    clr_instr();
    rst = 1;
    tick();
    chk("trap_rst_mis", {31'b0, misaligned}, 32'h0);
    chk("trap_rst_pc", pc, 32'h0);
    chk("trap_rst_instret", instret, 32'h0);

    // Reset asserted mid-fetch
    rst = 0;
    tick(); tick(); tick();  // RESET->FETCH->EXEC->FETCH, pc=4
    chk("refetch_pc", pc, 32'h4);
    imem_ready = 0;
    chk("refetch_req", {31'b0, imem_req}, 32'h1);
    rst = 1;
    tick();
    chk("fetch_rst_pc", pc, 32'h0);
    chk("fetch_rst_req", {31'b0, imem_req}, 32'h0);
    chk("fetch_rst_instret", instret, 32'h0);
    rst = 0; imem_ready = 1; #1;
    chk("fetch_rst_req1", {31'b0, imem_req}, 32'h0);
    tick();
    chk("fetch_rst_req2", {31'b0, imem_req}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
